encoder_ifelse: RTL and testbench
=================================

ENCODER_IFELSE -- requirements
Module: encoder_ifelse

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Data  input  8  request vector; bit i = request i.
REQ-005 Code  output  3  registered index of highest-priority asserted Data bit.
REQ-006 Valid  output  1  registered flag; 1 when the sampled Data had at least one bit set.

Function
REQ-007 Priority SHALL be highest-index-first: Data[7] highest, Data[0] lowest, as an if / else-if chain from bit 7 down to bit 0.
REQ-008 Combinational next code SHALL be 7 if Data[7]; else 6 if Data[6]; else 5 if Data[5]; else 4 if Data[4]; else 3 if Data[3]; else 2 if Data[2]; else 1 if Data[1]; else 0.
REQ-009 Code SHALL load the next code on every rising clk edge while rst_n=1; latency exactly 1 cycle from Data to Code.
REQ-010 Valid SHALL load (Data != 8'h00) on every rising clk edge while rst_n=1, same cycle as Code.
REQ-011 Data=8'h00 SHALL produce Code=3'd0 and Valid=0.
REQ-012 Data=8'h01 SHALL produce Code=3'd0 and Valid=1; Valid is the only way to distinguish this case from REQ-011.
REQ-013 Multiple set bits SHALL encode only the highest set bit; lower bits are ignored (e.g. 8'h81 -> 7, 8'h0A -> 3).
REQ-014 Outputs SHALL hold between edges; Data changes between edges SHALL have no effect until the next rising edge.
REQ-015 No handshake, enable or back-pressure; a new result is produced every cycle.
REQ-016 Data containing X/Z is outside the supported input range; no output value is required for it.

Reset
REQ-017 rst_n=0 SHALL force Code=3'd0 and Valid=0 immediately, without waiting for a clk edge.
REQ-018 While rst_n=0, outputs SHALL stay 0 regardless of Data or clk.
REQ-019 After rst_n is released, the first rising edge SHALL load the encoding of the Data present at that edge.
REQ-020 Reset asserted mid-operation SHALL discard the held result; no prior value reappears after release.

Verification
REQ-021 One-hot sweep: Data = 01, 02, 04, 08, 10, 20, 40, 80 (hex), one per cycle -> Code = 0..7 one cycle later, Valid=1 each time.
REQ-022 Zero input: Data=8'h00 -> Code=0, Valid=0; then Data=8'h01 -> Code=0, Valid=1.
REQ-023 Priority: Data=8'h81 -> Code=7; Data=8'h7F -> Code=6; Data=8'h0A -> Code=3; Data=8'hFF -> Code=7; Valid=1 for all.
REQ-024 Latency: Data changes from 8'h80 to 8'h04 just after an edge -> Code stays 7 until the next edge, then becomes 2.
REQ-025 Async reset: with Code=7 and Valid=1, drive rst_n=0 between edges -> Code=0 and Valid=0 at once; release with Data=8'h20 -> Code=5 and Valid=1 after the first edge.
REQ-026 Exhaustive: all 256 Data values, with the result checked one cycle later against a reference encoder -> Code and Valid match every time.

Source files
------------

// File: rtl/encoder_ifelse.sv
// encoder_ifelse
//   Registered 8-to-3 priority encoder. Bit 7 has the highest priority and
//   bit 0 the lowest. The index of the highest set request bit is captured
//   on every rising clock edge. A separate valid flag distinguishes
//   "bit 0 requested" from "nothing requested".
//
// Ports
//   clk    in   1  clock; all state updates on the rising edge
//   rst_n  in   1  asynchronous active-low reset; clears Code and Valid
//   Data   in   8  request vector, bit i = request i
//   Code   out  3  registered index of the highest-priority set Data bit
//   Valid  out  1  registered flag, 1 when the sampled Data was nonzero

module encoder_ifelse (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Data,
  output logic [2:0] Code,
  output logic       Valid
);

  logic [2:0] next_code;
  logic       next_valid;

  // The chain is written from bit 7 down so that the first matching branch
  // is the highest set bit. An all-zero request falls through to 0, and
  // next_valid disambiguates that case from a lone bit 0.
  always_comb begin
    next_code = 3'd0;
    if (Data[7])      next_code = 3'd7;
    else if (Data[6]) next_code = 3'd6;
    else if (Data[5]) next_code = 3'd5;
    else if (Data[4]) next_code = 3'd4;
    else if (Data[3]) next_code = 3'd3;
    else if (Data[2]) next_code = 3'd2;
    else if (Data[1]) next_code = 3'd1;
    else              next_code = 3'd0;
  end

  assign next_valid = (Data != 8'h00);

  // Code and Valid load together every cycle. Reset clears both at once,
  // so a result held before reset can never reappear after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Code  <= 3'd0;
      Valid <= 1'b0;
    end else begin
      Code  <= next_code;
      Valid <= next_valid;
    end
  end

endmodule

// File: tb/tb_encoder_ifelse.sv
// tb_encoder_ifelse
//   Self-checking bench for encoder_ifelse. A reference encoder derived
//   arithmetically (position of the most significant set bit) predicts
//   {Valid, Code} for directed vectors, an exhaustive sweep and random data.

module tb_encoder_ifelse;

  logic       clk;
  logic       rst_n;
  logic [7:0] Data;
  logic [2:0] Code;
  logic       Valid;

  int compareCount;
  int mismatchCount;

  encoder_ifelse dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Data  (Data),
    .Code  (Code),
    .Valid (Valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the highest set bit of a nonzero d is floor(log2(d)),
  // which equals clog2(d+1)-1. Zero maps to {valid=0, code=0}.
  function automatic logic [3:0] refEncode(input logic [7:0] d);
    int idx;
    if (d == 8'h00) return 4'b0000;
    idx = $clog2(int'(d) + 1) - 1;
    return {1'b1, 3'(idx)};
  endfunction

  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed {Valid,Code}=%b_%0d required %b_%0d",
               tag, observed[3], observed[2:0], expected[3], expected[2:0]);
    end
  endtask

  // Drive d away from the rising edge, then check the registered result
  // just after the next rising edge against the reference.
  task automatic applyStimulus(input string tag, input logic [7:0] d);
    @(negedge clk);
    Data = d;
    @(posedge clk);
    #1;
    checkOutput(tag, {Valid, Code}, refEncode(d));
  endtask

  initial begin
    logic [7:0] oneHot [8];
    logic [7:0] prio [4];
    logic [2:0] prioCode [4];
    logic [7:0] r;

    compareCount  = 0;
    mismatchCount = 0;
    rst_n = 1'b0;
    Data  = 8'hFF;

    // Outputs must stay zero while reset is held, despite clocks and data
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hold", {Valid, Code}, 4'b0000);
    @(negedge clk);
    Data = 8'h81;
    #2;
    checkOutput("reset_hold_data_change", {Valid, Code}, 4'b0000);

    // First edge after release loads the data present at that edge
    @(negedge clk);
    Data  = 8'h20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("first_after_reset", {Valid, Code}, 4'b1101);

    // One-hot sweep: Code follows the bit index, Valid always set
    for (int i = 0; i < 8; i++) oneHot[i] = 8'(1 << i);
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("onehot_%0d", i), oneHot[i]);
      checkOutput($sformatf("onehot_const_%0d", i), {Valid, Code}, {1'b1, 3'(i)});
    end

    // Zero input versus lone bit 0
    applyStimulus("zero", 8'h00);
    checkOutput("zero_const", {Valid, Code}, 4'b0000);
    applyStimulus("bit0", 8'h01);
    checkOutput("bit0_const", {Valid, Code}, 4'b1000);

    // Priority with several bits set
    prio[0] = 8'h81; prioCode[0] = 3'd7;
    prio[1] = 8'h7F; prioCode[1] = 3'd6;
    prio[2] = 8'h0A; prioCode[2] = 3'd3;
    prio[3] = 8'hFF; prioCode[3] = 3'd7;
    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("prio_%h", prio[i]), prio[i]);
      checkOutput($sformatf("prio_const_%h", prio[i]), {Valid, Code}, {1'b1, prioCode[i]});
    end

    // Latency: a change just after an edge must not show until the next edge
    applyStimulus("latency_80", 8'h80);
    Data = 8'h04;
    @(negedge clk);
    checkOutput("latency_hold", {Valid, Code}, 4'b1111);
    @(posedge clk);
    #1;
    checkOutput("latency_update", {Valid, Code}, 4'b1010);

    // Asynchronous reset mid-operation clears outputs without an edge
    applyStimulus("async_pre", 8'h80);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_clear", {Valid, Code}, 4'b0000);
    @(negedge clk);
    Data  = 8'h20;
    rst_n = 1'b1;
    #1;
    checkOutput("async_no_reappear", {Valid, Code}, 4'b0000);
    @(posedge clk);
    #1;
    checkOutput("async_release", {Valid, Code}, 4'b1101);

    // Exhaustive sweep of every request vector
    for (int i = 0; i < 256; i++)
      applyStimulus($sformatf("exh_%02h", i[7:0]), i[7:0]);

    // Random vectors
    for (int i = 0; i < 200; i++) begin
      r = 8'($urandom_range(0, 255));
      applyStimulus($sformatf("rand_%02h", r), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
